// File: rtl/dmr_pkg.sv
// Shared types and constants for the data-memory responder.
package dmr_pkg;

    localparam int WORD_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int N_LANES     = WORD_W / BYTE_W;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Old bytes where the lane enable is clear, new bytes where it is set.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0]  old_word,
        input logic [WORD_W-1:0]  new_word,
        input logic [N_LANES-1:0] wen
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < N_LANES; i++) begin
            if (wen[i]) merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmr_if.sv
// Request/response handshake bundle between the CPU data port and the responder.
interface dmr_if;
    import dmr_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [N_LANES-1:0]  req_wen;
    logic [WORD_W-1:0]   req_addr;
    logic [WORD_W-1:0]   req_wdata;
    logic                resp_valid;
    logic                resp_ready;
    logic [WORD_W-1:0]   resp_rdata;
    logic                resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmr_mem_array.sv
// Word-addressed register array with byte-lane writes and two async read ports.
module dmr_mem_array
    import dmr_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [N_LANES-1:0] wen,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    input  logic [ADDR_W-1:0]  test_addr,
    output logic [WORD_W-1:0]  test_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the whole array is cleared on reset, so it must stay a flop array
    // rather than map onto a RAM macro, which has no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int l = 0; l < N_LANES; l++) begin
                if (wen[l]) mem[addr][l*BYTE_W +: BYTE_W] <= wdata[l*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdata     = mem[addr];
    assign test_data = mem[test_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory bus: valid/ready request, programmable
// access latency, held response, plus a combinational debug read port.
module data_mem_responder
    import dmr_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmr_if.slave              bus,
    input  logic [ADDR_W-1:0] test_addr,
    output logic [WORD_W-1:0] test_data
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  hold_addr, hold_wdata;
    logic [N_LANES-1:0] hold_wen;
    logic [WORD_W-1:0]  rdata_q;
    logic               err_q;
    logic [WORD_W-1:0]  cur_word;
    logic [N_LANES-1:0] mem_wen;
    logic               accept, commit, addr_err;
    logic               req_ready_c, resp_valid_c;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign commit   = (state == WAIT) && (cnt == '0);
    assign addr_err = (hold_addr[1:0] != 2'b00) || (hold_addr[WORD_W-1:ADDR_W+2] != '0);
    // Errored requests must never touch storage.
    assign mem_wen  = (commit && !addr_err) ? hold_wen : '0;

    dmr_mem_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk       (clk),
        .reset     (reset),
        .addr      (hold_addr[ADDR_W+1:2]),
        .wen       (mem_wen),
        .wdata     (hold_wdata),
        .rdata     (cur_word),
        .test_addr (test_addr),
        .test_data (test_data)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_nxt = WAIT;
            end
            WAIT: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_wen   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= CNT_INIT;
                hold_addr  <= bus.req_addr;
                hold_wdata <= bus.req_wdata;
                hold_wen   <= bus.req_wen;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Response registers load only at commit and hold through RESP.
            if (commit) begin
                rdata_q <= addr_err ? '0 : merge_bytes(cur_word, hold_wdata, hold_wen);
                err_q   <= addr_err;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  test_addr0 = '0, test_addr1 = '0;
    logic [31:0] test_data0, test_data1;

    dmr_if bus0();
    dmr_if bus1();

    data_mem_responder #(.ADDR_W(5), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .test_addr(test_addr0), .test_data(test_data0)
    );
    data_mem_responder #(.ADDR_W(5), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .test_addr(test_addr1), .test_data(test_data1)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] model [2][32];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? bus1.req_ready : bus0.req_ready;
    endfunction
    function automatic logic get_valid(input bit sel);
        return sel ? bus1.resp_valid : bus0.resp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus1.resp_rdata : bus0.resp_rdata;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? bus1.resp_err : bus0.resp_err;
    endfunction

    task automatic set_req(input bit sel, input logic v, input logic [3:0] wen,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            bus1.req_valid = v; bus1.req_wen = wen; bus1.req_addr = a; bus1.req_wdata = d;
        end else begin
            bus0.req_valid = v; bus0.req_wen = wen; bus0.req_addr = a; bus0.req_wdata = d;
        end
    endtask

    task automatic set_resp_ready(input bit sel, input logic r);
        if (sel) bus1.resp_ready = r;
        else     bus0.resp_ready = r;
    endtask

    task automatic peek(input bit sel, input int idx, output logic [31:0] data);
        if (sel) test_addr1 = 5'(idx);
        else     test_addr0 = 5'(idx);
        #1;
        data = sel ? test_data1 : test_data0;
    endtask

    task automatic clear_models();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++) model[s][i] = '0;
    endtask

    // Drive one request, update the reference model and push the expected response.
    task automatic issue(input bit sel, input logic [31:0] a, input logic [3:0] wen,
                         input logic [31:0] d);
        exp_t e;
        bit   to;
        int   idx;
        idx = int'(a[6:2]);
        e.err = (a[1:0] != 2'b00) || (a[31:7] != '0);
        if (e.err) begin
            e.rdata = '0;
        end else begin
            for (int l = 0; l < 4; l++)
                if (wen[l]) model[sel][idx][l*8 +: 8] = d[l*8 +: 8];
            e.rdata = model[sel][idx];
        end
        sb.push_back(e);
        set_req(sel, 1'b1, wen, a, d);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!get_ready(sel)) begin to = 1'b0; break; end
        end
        check("accept_timeout", 32'(to), 32'd0);
        set_req(sel, 1'b0, 4'h0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    endtask

    // Wait for the response, check latency and payload, optionally stall, then handshake.
    task automatic collect(input bit sel, input int exp_lat, input int stall);
        exp_t        e;
        bit          to;
        int          n;
        logic [31:0] rd;
        logic        er;
        n  = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (get_valid(sel)) begin to = 1'b0; break; end
        end
        check("resp_timeout", 32'(to), 32'd0);
        e = sb.pop_front();
        check("latency", 32'(n), 32'(exp_lat));
        check("rdata", get_rdata(sel), e.rdata);
        check("err", 32'(get_err(sel)), 32'(e.err));
        check("ready_in_resp", 32'(get_ready(sel)), 32'd0);
        rd = get_rdata(sel);
        er = get_err(sel);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(get_valid(sel)), 32'd1);
            check("stall_rdata", get_rdata(sel), rd);
            check("stall_err", 32'(get_err(sel)), 32'(er));
            check("stall_ready", 32'(get_ready(sel)), 32'd0);
        end
        set_resp_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_resp_ready(sel, 1'b0);
        check("post_hs_valid", 32'(get_valid(sel)), 32'd0);
        check("post_hs_ready", 32'(get_ready(sel)), 32'd1);
    endtask

    task automatic scan_all(input bit sel, input string tag);
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            peek(sel, i, d);
            check(tag, d, model[sel][i]);
        end
    endtask

    // Accept a store, then assert reset while it is still waiting to commit.
    task automatic reset_mid_op(input bit sel);
        logic [31:0] d;
        set_req(sel, 1'b1, 4'hF, 32'h04, 32'h1234_5678);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 4'h0, '0, '0);
        check("rst_accepted", 32'(get_ready(sel)), 32'd0);
        #3 reset = 1'b1;
        #1;
        clear_models();
        check("rst_async_ready", 32'(get_ready(sel)), 32'd1);
        check("rst_async_valid", 32'(get_valid(sel)), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_after_valid", 32'(get_valid(sel)), 32'd0);
        check("rst_after_ready", 32'(get_ready(sel)), 32'd1);
        peek(sel, 1, d);
        check("rst_mem1", d, 32'd0);
    endtask

    logic [31:0] d;

    initial begin
        set_req(1'b0, 1'b0, 4'h0, '0, '0);
        set_req(1'b1, 1'b0, 4'h0, '0, '0);
        set_resp_ready(1'b0, 1'b0);
        set_resp_ready(1'b1, 1'b0);
        clear_models();

        // Reset asserted mid-cycle, outputs must respond without a clock edge.
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("reset_ready", 32'(bus0.req_ready), 32'd1);
        check("reset_valid", 32'(bus0.resp_valid), 32'd0);
        check("reset_rdata", bus0.resp_rdata, 32'd0);
        check("reset_err", 32'(bus0.resp_err), 32'd0);
        scan_all(1'b0, "reset_mem");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Full-word store then load.
        issue(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        collect(1'b0, 2, 0);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        collect(1'b0, 2, 0);
        peek(1'b0, 4, d);
        check("test_port_w4", d, 32'hDEAD_BEEF);

        // Byte-lane merge.
        issue(1'b0, 32'h20, 4'hF, 32'h1122_3344);
        collect(1'b0, 2, 0);
        issue(1'b0, 32'h20, 4'b0101, 32'hAABB_CCDD);
        collect(1'b0, 2, 0);
        peek(1'b0, 8, d);
        check("merge_w8", d, 32'h11BB_33DD);
        issue(1'b0, 32'h7C, 4'b1010, 32'hCAFE_F00D);
        collect(1'b0, 2, 0);

        // Misaligned and out-of-range accesses.
        issue(1'b0, 32'h13, 4'h0, 32'h0);
        collect(1'b0, 2, 0);
        issue(1'b0, 32'h80, 4'h0, 32'h0);
        collect(1'b0, 2, 0);
        issue(1'b0, 32'h80, 4'hF, 32'hFFFF_FFFF);
        collect(1'b0, 2, 0);
        issue(1'b0, 32'h22, 4'hF, 32'h5555_5555);
        collect(1'b0, 2, 0);
        scan_all(1'b0, "err_no_write");

        // Backpressure on a load.
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        collect(1'b0, 2, 5);

        // Reset during WAIT.
        reset_mid_op(1'b0);

        // Single-edge latency instance.
        issue(1'b1, 32'h04, 4'hF, 32'h0BAD_CAFE);
        collect(1'b1, 1, 0);
        issue(1'b1, 32'h04, 4'b0011, 32'h0000_1234);
        collect(1'b1, 1, 2);
        peek(1'b1, 1, d);
        check("lat1_w1", d, 32'h0BAD_1234);
        reset_mid_op(1'b1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts load/store requests over a valid/ready handshake, applies a programmable access latency, and returns read data with a held response.
- Replaces the zero-latency data RAM so the core (later multi-cycle/pipelined) can be exercised against realistic memory timing.
- Also provides a combinational debug read port for the board display path.

Parameters:
- ADDR_W, 5, word-index width; storage is 2**ADDR_W 32-bit words, byte address bits [ADDR_W+1:2] select the word.
- LATENCY, 2, clock edges from request accept to resp_valid rising; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  4  byte write enables; 4'b0000 means a read; bit i writes byte lane i (bits 8i+7:8i).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  word at the addressed location after any write has been applied.
- resp_err  out  1  request was misaligned or out of range.
- test_addr  in  ADDR_W  debug word index.
- test_data  out  32  combinational mem[test_addr].

Behaviour:
- States: IDLE, WAIT, RESP; encoding is in the package.
- Reset (async assert):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - All storage words cleared to 0.
  - Any in-flight request is discarded; a pending write is never committed.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&req_ready: capture req_addr, req_wen and req_wdata into holding registers; load cnt=LATENCY-1; go to WAIT.
  - req_* are don't-care after the accept edge.
- WAIT:
  - req_ready=0.
  - Each edge with cnt!=0 decrements cnt.
  - The edge with cnt==0 commits the access and goes to RESP. resp_valid therefore rises exactly LATENCY edges after the accept edge.
- Commit, addr = captured address:
  - err = (addr[1:0]!=0) | (addr[31:ADDR_W+2]!=0).
  - If err: no write; resp_rdata=0; resp_err=1.
  - Otherwise: write each byte lane enabled in wen; resp_rdata = the merged word (old bytes where wen=0, new bytes where wen=1); resp_err=0.
  - Reads (wen=0) return the stored word unchanged.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until the handshake.
  - On an edge with resp_valid&resp_ready: resp_valid goes to 0 and state goes to IDLE.
  - req_ready is 0 throughout RESP. The next request can be accepted at the earliest on the edge after the response handshake.
  - Back-to-back throughput is 1 transaction per LATENCY+2 cycles.
- resp_ready asserted outside RESP is ignored. req_valid asserted outside IDLE is ignored; the requester must hold it.
- test_data:
  - Purely combinational from storage.
  - Shows a committed write from the cycle after the commit edge.
  - Unaffected by the handshake state.
- Storage uses no registered output, so resp_rdata is a flop loaded only at commit. Outputs are glitch-free apart from test_data.

Decomposition:
- Package dmr_pkg:
  - State enum: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Byte-lane width constant 8.
  - Maximum latency constant 15.
  - Counter width constant 4.
- Sub-module dmr_mem_array:
  - 2**ADDR_W x 32 register array.
  - Async clear on reset.
  - Byte-enable write port.
  - Two async read ports: one for commit/merge, one for test.
- The top level holds the FSM, the counter, the holding registers and the response registers.

Test Plan:
- Reset then idle: assert reset mid-cycle -> req_ready=1, resp_valid=0, test_data=0 for test_addr=0..31.
- Full-word store then load, LATENCY=2:
  - Store 32'hDEADBEEF to addr 0x10 with wen=4'hF -> resp_valid rises 2 edges after accept with rdata=32'hDEADBEEF, err=0.
  - Load 0x10 -> rdata=32'hDEADBEEF; test_addr=4 shows 32'hDEADBEEF.
- Byte-lane merge: word 0x20 holds 32'h11223344; store wdata=32'hAABBCCDD with wen=4'b0101 -> rdata=32'h11BB33DD.
- Errors: load from addr 0x13 (misaligned) and from addr 0x80 (out of range, ADDR_W=5) -> err=1, rdata=0. A store to 0x80 leaves all words unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable and req_ready=0. Then raise resp_ready -> req_ready=1 on the next cycle.
- Reset mid-operation: assert reset during WAIT of a store of 32'h12345678 to 0x04 -> after release, resp_valid=0, state IDLE, mem[1]=0. Repeat with LATENCY=1 -> response one edge after accept.
